// File: rtl/mmio_uart.sv
// Memory-mapped console/test-status slave for the picorv32 native bus.
// Byte writes to TXDATA are queued in a FIFO and shifted out as 8N1 serial frames.
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        tests_passed
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]   TEST_MAGIC = 32'd123456789;
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TEST   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Bus handshake: a request is taken on the edge where mem_valid is high, the
  // address is in the window, mem_ready is low and a TXDATA push would not
  // overflow; mem_ready/mem_rdata are then high/valid for exactly the next
  // cycle, and mem_rdata is zero otherwise so the interconnect can OR it.
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              tests_passed_q, tests_passed_d;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic              sel;
  logic [1:0]        reg_off;
  logic              is_write;
  logic              push_req;
  logic              full;
  logic              empty;
  logic              busy;
  logic              accept;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic [7:0]        fifo_head;
  logic [7:0]        count_byte;
  logic [31:0]       rdata_mux;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign mem_ready    = mem_ready_q;
  assign mem_rdata    = mem_rdata_q;
  assign uart_tx      = tx_q;
  assign tests_passed = tests_passed_q;

  assign fifo_head = fifo_mem_q[rd_ptr_q];
  assign full      = (count_q == FIFO_FULL);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != ST_IDLE);
  assign bit_end   = (cnt_q == BIT_LAST);

  // Bus decode, register read mux and register writes.
  always_comb begin
    sel      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    reg_off  = mem_addr[3:2];
    is_write = |mem_wstrb;
    push_req = (reg_off == OFF_TXDATA) && mem_wstrb[0];
    // A full FIFO holds the push off rather than dropping it.
    accept   = mem_valid && sel && !mem_ready_q && !(push_req && full);
    push     = accept && push_req;

    count_byte = '0;
    count_byte[CW-1:0] = count_q;

    rdata_mux = '0;
    case (reg_off)
      OFF_STATUS: rdata_mux = {16'h0, count_byte, 5'b0, busy, full, empty};
      OFF_TEST:   rdata_mux = {31'b0, tests_passed_q};
      default:    rdata_mux = '0;
    endcase

    mem_ready_d    = accept;
    mem_rdata_d    = accept ? rdata_mux : 32'h0;
    tests_passed_d = tests_passed_q |
                     (accept && is_write && (reg_off == OFF_TEST) &&
                      (mem_wdata == TEST_MAGIC));
  end

  // Transmit FSM: a START/DATA/STOP bit each lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_ready_q    <= 1'b0;
      mem_rdata_q    <= 32'h0;
      tests_passed_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_q          <= 3'd0;
      shift_q        <= 8'h00;
      tx_q           <= 1'b1;
    end else begin
      mem_ready_q    <= mem_ready_d;
      mem_rdata_q    <= mem_rdata_d;
      tests_passed_q <= tests_passed_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: bus register access, serial framing,
// FIFO full stall, sticky test flag, address decode and mid-frame reset.
module tb_mmio_uart;

  localparam int          CPB    = 16;
  localparam int          FRAME  = 10 * CPB;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] TXDATA = BASE;
  localparam logic [31:0] STATUS = BASE + 32'd4;
  localparam logic [31:0] TEST   = BASE + 32'd8;
  localparam logic [31:0] UNMAP  = BASE + 32'd12;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        tests_passed;

  int cyc = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  logic       mon_active = 1'b0;
  int         mon_j;
  int         mon_err;
  int         mon_idx;
  logic       mon_lvl;
  logic [7:0] mon_exp;
  logic [7:0] mon_rx;

  mmio_uart #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .uart_tx     (uart_tx),
    .tests_passed(tests_passed)
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial line scoreboard: every sampled cycle of a frame is compared
  // against the ideal 8N1 waveform of the next expected byte.
  always @(negedge clock) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_j      = 0;
        mon_err    = 0;
        mon_rx     = 8'h00;
        frame_starts.push_back(cyc);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
        else mon_exp = 8'h00;
      end
      if (mon_active) begin
        mon_idx = mon_j / CPB;
        if (mon_idx == 0) mon_lvl = 1'b0;
        else if (mon_idx == 9) mon_lvl = 1'b1;
        else mon_lvl = mon_exp[mon_idx-1];
        if (uart_tx !== mon_lvl) mon_err++;
        if ((mon_j % CPB) == CPB / 2 && mon_idx >= 1 && mon_idx <= 8)
          mon_rx[mon_idx-1] = uart_tx;
        mon_j++;
        if (mon_j == FRAME) begin
          chk("frame_shape_errs", 32'(mon_err), 32'd0);
          chk("frame_byte", 32'(mon_rx), 32'(mon_exp));
          mon_active = 1'b0;
        end
      end
    end
  end

  // Driver: one bus request, bounded wait for mem_ready.
  task automatic bus_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int budget,
                         output logic [31:0] rdata, output int acc,
                         output int waits, output bit ok);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    ok    = 1'b0;
    rdata = 32'h0;
    acc   = -1;
    waits = 0;
    while (!ok && waits < budget) begin
      @(posedge clock);
      #1;
      waits++;
      if (mem_ready === 1'b1) begin
        ok    = 1'b1;
        rdata = mem_rdata;
        acc   = cyc;
      end
    end
    @(negedge clock);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, output int acc, output int waits);
    logic [31:0] rd_unused;
    bit ok;
    bus_req(addr, data, strb, 400, rd_unused, acc, waits, ok);
    chk("wr_done", 32'(ok), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc);
    int waits;
    wr(TXDATA, {24'h0, b}, 4'b0001, acc, waits);
    exp_q.push_back(b);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    int acc, waits;
    bit ok;
    bus_req(addr, 32'h0, 4'h0, 20, data, acc, waits, ok);
    chk("rd_done", 32'(ok), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 32'd1);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv;
    int acc, waits, lead_acc, acc15, acc16, seen;

    // Reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_tests_passed", 32'(tests_passed), 32'd0);
    rd(STATUS, rdv);
    chk("rst_status", rdv, 32'h0000_0001);

    // Register map corners
    rd(TXDATA, rdv);
    chk("txdata_read_zero", rdv, 32'h0);
    rd(UNMAP, rdv);
    chk("unmapped_read_zero", rdv, 32'h0);
    wr(UNMAP, 32'hFFFF_FFFF, 4'hF, acc, waits);
    wr(TXDATA, 32'h0000_0077, 4'b0010, acc, waits);
    wr(STATUS, 32'hFFFF_FFFF, 4'hF, acc, waits);
    rd(STATUS, rdv);
    chk("status_after_nopush", rdv, 32'h0000_0001);

    // Single byte 0x41
    frame_starts.delete();
    push_byte(8'h41, acc);
    chk("wr_latency", 32'(waits), 32'd1);
    @(posedge clock);
    #1;
    chk("ready_one_cycle", 32'(mem_ready), 32'd0);
    drain(FRAME + 50);
    chk("single_frame_count", 32'(frame_starts.size()), 32'd1);
    chk("idle_after_frame", 32'(uart_tx), 32'd1);

    // Status while first frame in progress
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    push_byte(8'h33, acc);
    rd(STATUS, rdv);
    chk("status_count2_busy", rdv, 32'h0000_0204);
    drain(3 * FRAME + 50);

    // Full stall: lead byte occupies the shifter, then 17 bytes
    frame_starts.delete();
    push_byte(8'h55, lead_acc);
    acc15 = -1;
    acc16 = -1;
    for (int k = 0; k < 17; k++) begin
      push_byte(8'(k), acc);
      if (k == 15) acc15 = acc;
      if (k == 16) acc16 = acc;
    end
    chk("byte15_no_stall", 32'(acc15 - lead_acc), 32'd32);
    chk("byte16_stall_release", 32'(acc16 - lead_acc), 32'(FRAME + 2));
    drain(18 * FRAME + 200);
    chk("burst_frame_count", 32'(frame_starts.size()), 32'd18);
    for (int i = 1; i < 18 && i < frame_starts.size(); i++)
      chk("burst_gap", 32'(frame_starts[i] - frame_starts[i-1]), 32'(FRAME));
    rd(STATUS, rdv);
    chk("status_after_burst", rdv, 32'h0000_0001);

    // Test flag
    wr(TEST, 32'd5, 4'hF, acc, waits);
    chk("flag_after_5", 32'(tests_passed), 32'd0);
    wr(TEST, 32'd123456789, 4'hF, acc, waits);
    chk("flag_after_magic", 32'(tests_passed), 32'd1);
    wr(TEST, 32'd0, 4'hF, acc, waits);
    chk("flag_sticky", 32'(tests_passed), 32'd1);
    rd(TEST, rdv);
    chk("test_read", rdv, 32'h0000_0001);

    // Out-of-window request
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = 32'h2000_0000;
    mem_wdata = 32'h0000_0099;
    mem_wstrb = 4'b0001;
    seen = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (mem_ready !== 1'b0) seen++;
    end
    @(negedge clock);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    chk("decode_no_ready", 32'(seen), 32'd0);
    rd(STATUS, rdv);
    chk("decode_no_push", rdv, 32'h0000_0001);

    // Reset at cycle 50 of a frame
    push_byte(8'h00, acc);
    repeat (51) @(posedge clock);
    #2;
    chk("midframe_line_low", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("midframe_reset_tx_high", 32'(uart_tx), 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("post_reset_tx", 32'(uart_tx), 32'd1);
    chk("post_reset_flag", 32'(tests_passed), 32'd0);
    rd(STATUS, rdv);
    chk("post_reset_status", rdv, 32'h0000_0001);
    repeat (2 * FRAME) @(negedge clock);
    chk("post_reset_line_idle", 32'(uart_tx), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
